// File: rtl/spi_pkg.sv
// Shared SPI controller definitions: receive FSM encoding, SPI mode constants and
// STATUS_REG bit positions for the receive FIFO flags.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StPush  = 2'd2
  } rx_state_e;

  // Mode constants are {cpol, cpha}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned RXFO = 0;
  localparam int unsigned RXFF = 1;
  localparam int unsigned RXFE = 2;

  // spi_clk level reached by a sample edge: rising for modes 0/3, falling for modes 1/2.
  function automatic logic sample_level(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive FIFO: circular buffer with wrapping pointers, separate entry count, empty/full
// flags and a sticky overflow bit. Head word is presented show-ahead and reads 0 when empty.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  input  logic                  clear_ov,
  output logic [WIDTH-1:0]      rdata,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DepthInt = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = DepthInt[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem_q [DepthInt];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ov_q, ov_d;
  logic                  push_ok, pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DepthCnt);
  assign overflow = ov_q;
  assign level    = count_q;
  assign rdata    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push_ok  = push & (~full | pop);
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ov_d     = ov_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
    if (push && !push_ok) ov_d = 1'b1;
    else if (clear_ov)    ov_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ov_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ov_q     <= ov_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_rx_capture.sv
// SPI receive capture: detects the mode-correct sample edge of spi_clk, shifts spi_rx in
// MSB first and pushes each completed word into spi_rx_fifo.
// Optional feature: define SPI_RX_LOOPBACK_EN to allow an internal MOSI->MISO loopback.
module spi_rx_capture
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_clk,
  input  logic                xfer_active,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [4:0]          word_size,
  input  logic                spi_rx,
  input  logic                spi_tx,
  input  logic                loopback,
  input  logic                pop,
  input  logic                clear_ov,
  output logic [WIDTH-1:0]    rx_data,
  output logic                rxfe,
  output logic                rxff,
  output logic                rxfo,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic [1:0]          state
);

  rx_state_e        state_q, state_d;
  logic             sclk_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [4:0]       bits_left_q, bits_left_d;
  logic             armed_q, armed_d;
  logic             sample_edge;
  logic             rx_bit;
  logic             push;

`ifdef SPI_RX_LOOPBACK_EN
  assign rx_bit = loopback ? spi_tx : spi_rx;
`else
  logic unused_loopback;
  assign unused_loopback = loopback ^ spi_tx;
  assign rx_bit = spi_rx;
`endif

  assign sample_edge = (spi_clk != sclk_q) && (spi_clk == sample_level(cpol, cpha));
  assign state       = state_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    push        = 1'b0;
    // A window is only captured once: re-arm after xfer_active has been seen low.
    armed_d     = armed_q | ~xfer_active;
    unique case (state_q)
      StIdle: begin
        if (xfer_active && armed_q) begin
          shift_d     = '0;
          bits_left_d = word_size;
          armed_d     = 1'b0;
          state_d     = StShift;
        end
      end
      StShift: begin
        if (!xfer_active) begin
          state_d = StIdle;
        end else if (sample_edge) begin
          shift_d = {shift_q[WIDTH-2:0], rx_bit};
          if (bits_left_q == 5'd0) state_d = StPush;
          else                     bits_left_d = bits_left_q - 5'd1;
        end
      end
      StPush: begin
        push    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sclk_q      <= 1'b0;
      shift_q     <= '0;
      bits_left_q <= '0;
      armed_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      sclk_q      <= spi_clk;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      armed_q     <= armed_d;
    end
  end

  spi_rx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wdata    (shift_q),
    .pop      (pop),
    .clear_ov (clear_ov),
    .rdata    (rx_data),
    .empty    (rxfe),
    .full     (rxff),
    .overflow (rxfo),
    .level    (rx_level)
  );

endmodule

// File: tb/tb_spi_rx_capture.sv
// Self-checking bench for spi_rx_capture: drives SPI words in all four modes and checks
// FIFO contents and flags against a queue-based model of the receive path.
module tb_spi_rx_capture;

  localparam int H = 2;  // spi_clk half period in clk cycles

  logic        clk = 1'b0;
  logic        reset, spi_clk, xfer_active, cpol, cpha, spi_rx, spi_tx, loopback, pop, clear_ov;
  logic [4:0]  word_size;
  logic [31:0] rx_data;
  logic        rxfe, rxff, rxfo;
  logic [4:0]  rx_level;
  logic [1:0]  state;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_q[$];
  logic        model_ov = 1'b0;

  always #5 clk = ~clk;

  spi_rx_capture dut (
    .clk         (clk),
    .reset       (reset),
    .spi_clk     (spi_clk),
    .xfer_active (xfer_active),
    .cpol        (cpol),
    .cpha        (cpha),
    .word_size   (word_size),
    .spi_rx      (spi_rx),
    .spi_tx      (spi_tx),
    .loopback    (loopback),
    .pop         (pop),
    .clear_ov    (clear_ov),
    .rx_data     (rx_data),
    .rxfe        (rxfe),
    .rxff        (rxff),
    .rxfo        (rxfo),
    .rx_level    (rx_level),
    .state       (state)
  );

  function automatic logic [31:0] mask_word(input logic [31:0] data, input int ws);
    logic [63:0] m;
    m = (64'd1 << (ws + 1)) - 64'd1;
    return data & m[31:0];
  endfunction

  function automatic logic [31:0] model_head();
    return (model_q.size() != 0) ? model_q[0] : 32'd0;
  endfunction

  function automatic void model_push(input logic [31:0] data, input int ws);
    if (model_q.size() < 16) model_q.push_back(mask_word(data, ws));
    else model_ov = 1'b1;
  endfunction

  task automatic start_word(input logic [1:0] mode, input logic [4:0] ws);
    cpol = mode[1];
    cpha = mode[0];
    spi_clk = mode[1];
    word_size = ws;
    repeat (3) @(negedge clk);
    xfer_active = 1'b1;
    @(negedge clk);
    word_size = 5'($urandom);  // must not affect the word in flight
  endtask

  // Returns right after the sample toggle of the last bit sent.
  task automatic send_bits(input logic [31:0] data, input int msb, input int count);
    for (int k = 0; k < count; k++) begin
      spi_rx = data[msb-k] ^ loopback;
      spi_tx = data[msb-k] ^ ~loopback;
      if (cpha) begin
        repeat (H) @(negedge clk);
        spi_clk = ~spi_clk;
      end
      repeat (H) @(negedge clk);
      spi_clk = ~spi_clk;
      if (k != count - 1) begin
        if (!cpha) begin
          repeat (H) @(negedge clk);
          spi_clk = ~spi_clk;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic finish_word();
    if (!cpha) begin
      repeat (H) @(negedge clk);
      spi_clk = ~spi_clk;
    end
    repeat (H) @(negedge clk);
    xfer_active = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [1:0] mode, input int ws, input logic [31:0] data);
    start_word(mode, 5'(ws));
    send_bits(data, ws, ws + 1);
    repeat (2) @(negedge clk);
    finish_word();
    model_push(data, ws);
  endtask

  task automatic pop_word();
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (rx_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", rx_level); end
    total++; if ({rxfe, rxff, rxfo} !== 3'b100) begin
      bad++; $display("FAIL reset_flags got fe/ff/fo=%b%b%b exp=100", rxfe, rxff, rxfo);
    end
    total++; if (rx_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", rx_data); end
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) begin
      start_word(2'(m), 5'd7);
      send_bits(32'hA5, 7, 8);
      @(negedge clk);
      total++; if (state !== 2'd2 || rxfe !== 1'b1) begin
        bad++; $display("FAIL mode%0d_push_cycle got state=%0d rxfe=%b exp state=2 rxfe=1", m, state, rxfe);
      end
      @(negedge clk);
      model_push(32'hA5, 7);
      total++; if (rxfe !== 1'b0 || rx_data !== model_head()) begin
        bad++; $display("FAIL mode%0d_capture got rxfe=%b data=%h exp rxfe=0 data=%h", m, rxfe, rx_data,
                        model_head());
      end
      finish_word();
      total++; if (rx_level !== 5'd1) begin
        bad++; $display("FAIL mode%0d_single_capture got level=%0d exp=1", m, rx_level);
      end
      pop_word();
      total++; if (rxfe !== 1'b1 || rx_data !== 32'd0) begin
        bad++; $display("FAIL mode%0d_pop got rxfe=%b data=%h exp rxfe=1 data=0", m, rxfe, rx_data);
      end
    end
  endtask

  task automatic test_sizes();
    send_word(2'd3, 31, 32'hDEADBEEF);
    send_word(2'd0, 3, 32'hFFFFFFFF);
    total++; if (rx_level !== 5'd2 || rx_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL size32_head got level=%0d data=%h exp level=2 data=deadbeef", rx_level, rx_data);
    end
    pop_word();
    total++; if (rx_data !== 32'h0000000F) begin
      bad++; $display("FAIL size4_head got=%h exp=0000000f", rx_data);
    end
    pop_word();
    for (int i = 0; i < 6; i++) begin
      send_word(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)), $urandom);
    end
    total++; if (rx_level !== 5'(model_q.size())) begin
      bad++; $display("FAIL rand_level got=%0d exp=%0d", rx_level, model_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      total++; if (rx_data !== model_head()) begin
        bad++; $display("FAIL rand_word%0d got=%h exp=%h", i, rx_data, model_head());
      end
      pop_word();
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 17; i++) send_word(2'($urandom_range(0, 3)), 15, $urandom);
    total++; if (rxff !== 1'b1 || rx_level !== 5'd16 || rxfo !== model_ov) begin
      bad++; $display("FAIL overflow_flags got ff=%b level=%0d fo=%b exp ff=1 level=16 fo=%b", rxff, rx_level,
                      rxfo, model_ov);
    end
    total++; if (rx_data !== model_head()) begin
      bad++; $display("FAIL overflow_head got=%h exp=%h", rx_data, model_head());
    end
    @(negedge clk); clear_ov = 1'b1; @(negedge clk); clear_ov = 1'b0;
    model_ov = 1'b0;
    total++; if (rxfo !== 1'b0) begin bad++; $display("FAIL clear_ov got=%b exp=0", rxfo); end
    // Push and pop in the same cycle while full.
    d = $urandom;
    start_word(2'd1, 5'd15);
    send_bits(d, 15, 16);
    @(negedge clk); pop = 1'b1;
    @(negedge clk); pop = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back(mask_word(d, 15));
    finish_word();
    total++; if (rx_level !== 5'd16 || rxfo !== 1'b0 || rx_data !== model_head()) begin
      bad++; $display("FAIL full_push_pop got level=%0d fo=%b data=%h exp level=16 fo=0 data=%h", rx_level,
                      rxfo, rx_data, model_head());
    end
    // Overflow in the same cycle as clear_ov.
    d = $urandom;
    start_word(2'd2, 5'd15);
    send_bits(d, 15, 16);
    @(negedge clk); clear_ov = 1'b1;
    @(negedge clk); clear_ov = 1'b0;
    model_ov = 1'b1;
    total++; if (rxfo !== model_ov || rx_level !== 5'd16 || rx_data !== model_head()) begin
      bad++; $display("FAIL ov_vs_clear got fo=%b level=%0d data=%h exp fo=1 level=16 data=%h", rxfo,
                      rx_level, rx_data, model_head());
    end
    finish_word();
    for (int i = 0; i < 16; i++) begin
      total++; if (rx_data !== model_head()) begin
        bad++; $display("FAIL drain%0d got=%h exp=%h", i, rx_data, model_head());
      end
      pop_word();
    end
    pop_word();
    total++; if (rx_level !== 5'd0 || rxfe !== 1'b1 || rxff !== 1'b0) begin
      bad++; $display("FAIL pop_empty got level=%0d fe=%b ff=%b exp level=0 fe=1 ff=0", rx_level, rxfe, rxff);
    end
    @(negedge clk); clear_ov = 1'b1; @(negedge clk); clear_ov = 1'b0;
    model_ov = 1'b0;
  endtask

  task automatic test_abort();
    start_word(2'd0, 5'd7);
    send_bits(32'hA5, 7, 4);
    repeat (H) @(negedge clk);
    xfer_active = 1'b0;
    spi_clk = cpol;
    repeat (4) @(negedge clk);
    total++; if (rxfe !== 1'b1 || rx_level !== 5'd0 || state !== 2'd0) begin
      bad++; $display("FAIL abort got fe=%b level=%0d state=%0d exp fe=1 level=0 state=0", rxfe, rx_level,
                      state);
    end
  endtask

  task automatic test_reset_mid();
    send_word(2'd0, 7, 32'h5A);
    start_word(2'd3, 5'd7);
    send_bits(32'hC3, 7, 5);
    reset = 1'b1;
    #1;
    total++; if (state !== 2'd0 || rx_level !== 5'd0) begin
      bad++; $display("FAIL reset_async got state=%0d level=%0d exp 0/0", state, rx_level);
    end
    @(negedge clk);
    xfer_active = 1'b0;
    spi_clk = 1'b0;
    model_q.delete();
    model_ov = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({rxfe, rxff, rxfo} !== 3'b100 || rx_data !== 32'd0 || state !== 2'd0) begin
      bad++; $display("FAIL reset_mid got fe/ff/fo=%b%b%b data=%h state=%0d exp 100/0/0", rxfe, rxff, rxfo,
                      rx_data, state);
    end
  endtask

`ifdef SPI_RX_LOOPBACK_EN
  task automatic test_loopback();
    loopback = 1'b1;
    send_word(2'd0, 7, 32'h3C);
    total++; if (rx_data !== 32'h3C) begin bad++; $display("FAIL loopback got=%h exp=3c", rx_data); end
    pop_word();
    loopback = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    spi_clk = 1'b0;
    xfer_active = 1'b0;
    cpol = 1'b0;
    cpha = 1'b0;
    word_size = 5'd7;
    spi_rx = 1'b0;
    spi_tx = 1'b0;
    loopback = 1'b0;
    pop = 1'b0;
    clear_ov = 1'b0;
    test_reset();
    test_modes();
    test_sizes();
    test_overflow();
    test_abort();
    test_reset_mid();
`ifdef SPI_RX_LOOPBACK_EN
    test_loopback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
